instruction_memory_loadable: RTL
================================

INSTRUCTION_MEMORY_LOADABLE -- requirements
Module: instruction_memory_loadable

Interface
REQ-001 Parameter ADDR_W, default 8: fetch/load address width.
REQ-002 Parameter INST_W, default 16: instruction word width; SHALL be an integer multiple of LOAD_W.
REQ-003 Parameter LOAD_W, default 8: loader beat width.
REQ-004 Parameter DEPTH, default 256: implemented words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-005 Parameter HALT_WORD, default 16'hC000: power-up content and out-of-range fetch result.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 load_en  input  1  level; high requests/holds loader mode.
REQ-009 load_valid  input  1  qualifies load_data for one beat.
REQ-010 load_data  input  LOAD_W  loader beat, most-significant beat of each word first.
REQ-011 fetch_req  input  1  read request, one per cycle max.
REQ-012 fetch_addr  input  ADDR_W  word address of request.
REQ-013 inst  output  INST_W  registered fetched instruction.
REQ-014 inst_valid  output  1  one-cycle pulse, inst holds new data.
REQ-015 busy  output  1  high while in LOAD state.
REQ-016 load_ovf  output  1  sticky; loader attempted write past DEPTH-1.
REQ-017 load_count  output  ADDR_W+1  words written in current/last load session.

Function
REQ-018 FSM states RUN and LOAD only; RUN -> LOAD when load_en=1; LOAD -> RUN when load_en=0.
REQ-019 Entering LOAD SHALL clear word pointer, beat counter, assembly register, load_count and load_ovf.
REQ-020 In LOAD, each load_valid beat SHALL shift load_data into assembly register from MSB side; beats with load_valid=0 SHALL be ignored.
REQ-021 On the INST_W/LOAD_W-th beat the assembled word SHALL be written at the pointer on that edge; pointer and load_count increment, beat counter clears.
REQ-022 Pointer does not wrap: a completed word when pointer = DEPTH SHALL be discarded and load_ovf set; memory unchanged.
REQ-023 Leaving LOAD with partial word (beat counter nonzero) SHALL discard it; no write.
REQ-024 In RUN, fetch_req=1 at edge N SHALL give inst=mem[fetch_addr], inst_valid=1 after edge N (latency 1 cycle); back-to-back requests SHALL yield back-to-back valid pulses.
REQ-025 fetch_addr >= DEPTH SHALL return HALT_WORD with inst_valid=1.
REQ-026 fetch_req in LOAD, or in the RUN cycle where load_en=1 (load wins), SHALL be dropped: inst_valid=0, inst unchanged.
REQ-027 Without a served request inst SHALL hold its last value; inst_valid=0.
REQ-028 Fetch in the cycle after a write to the same address SHALL return the new word.
REQ-029 busy = (state == LOAD), registered; load_count/load_ovf held while in RUN.

Reset
REQ-030 reset=1 SHALL immediately force state RUN, inst=0, inst_valid=0, busy=0, load_ovf=0, load_count=0, pointer/beat counter=0.
REQ-031 Memory SHALL power up with HALT_WORD in every location; reset SHALL NOT alter memory.
REQ-032 Reset mid-load SHALL abandon the session: completed words remain written, partial word discarded.

Verification
REQ-033 Power-up, reset, fetch_req addr 0x05 -> next cycle inst=16'hC000, inst_valid=1.
REQ-034 load_en=1, beats 0x41,0x03,0x42,0x00, load_en=0; fetch 0 then 1 back-to-back -> inst 16'h4103 then 16'h4200 on consecutive cycles, load_count=2.
REQ-035 DEPTH=4: load 5 words (10 beats) -> load_ovf=1, load_count=4, fetch 3 returns 4th word, fetch 4 returns HALT_WORD.
REQ-036 Load 3 beats (0x91,0x06,0x12) then load_en=0 -> load_count=1, fetch 1 returns prior content (HALT_WORD).
REQ-037 In RUN, fetch_req=1 and load_en=1 same cycle -> inst_valid=0 next cycle, busy=1; reset asserted after 1 full word + 1 beat -> busy=0 immediately, word 0 retained, word 1 unchanged.

Source files
------------

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory.
// A byte-serial loader fills the memory while in LOAD mode. Each word arrives
// most-significant beat first. In RUN mode the memory serves registered
// single-cycle fetches.
// Handshake: a loader beat is accepted on a rising edge only when the FSM is in
// LOAD and load_valid=1. A fetch is accepted on a rising edge only when the FSM
// is in RUN, load_en=0 and fetch_req=1. An accepted fetch produces a one-cycle
// inst_valid pulse after that edge. There is no backpressure on either side.
module instruction_memory_loadable #(
   parameter int ADDR_W = 8,
   parameter int INST_W = 16,
   parameter int LOAD_W = 8,
   parameter int DEPTH  = 256,
   parameter logic [INST_W-1:0] HALT_WORD = 16'hC000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic              load_valid,
   input  logic [LOAD_W-1:0] load_data,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   output logic              busy,
   output logic              load_ovf,
   output logic [ADDR_W:0]   load_count
);

   localparam int BEATS  = INST_W / LOAD_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic {ST_RUN, ST_LOAD} state_t;

   state_t              state;
   state_t              next_state;
   logic [ADDR_W:0]     ptr;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [INST_W-1:0]   asm_reg;
   logic [INST_W-1:0]   shifted;
   logic                beat_ok;
   logic                last_beat;
   logic                wr_en;
   logic                fetch_ok;
   logic                in_range;

   // Contents survive reset; only the power-up value is HALT_WORD.
   logic [INST_W-1:0] mem [DEPTH] = '{default: HALT_WORD};

   // Newest beat enters at the bottom, so the first beat ends up in the MSBs.
   assign shifted   = (asm_reg << LOAD_W) | INST_W'(load_data);
   assign beat_ok   = (state == ST_LOAD) && load_valid;
   assign last_beat = (beat_cnt == LAST_BEAT);
   // Pointer saturates at DEPTH; completed words beyond that are dropped.
   assign wr_en     = beat_ok && last_beat && (ptr < DEPTH_C);
   assign fetch_ok  = (state == ST_RUN) && !load_en && fetch_req;
   assign in_range  = ({1'b0, fetch_addr} < DEPTH_C);

   assign busy       = (state == ST_LOAD);
   assign load_count = ptr;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         state <= next_state;
      end
   end

   // Mode selection follows the load_en level.
   always_comb begin
      next_state = state;
      case (state)
         ST_RUN:  if (load_en)  next_state = ST_LOAD;
         ST_LOAD: if (!load_en) next_state = ST_RUN;
         default: next_state = ST_RUN;
      endcase
   end

   // Loader datapath: session clear on entry, beat assembly, word pointer, overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr      <= '0;
         beat_cnt <= '0;
         asm_reg  <= '0;
         load_ovf <= 1'b0;
      end else if (state == ST_RUN) begin
         if (load_en) begin
            ptr      <= '0;
            beat_cnt <= '0;
            asm_reg  <= '0;
            load_ovf <= 1'b0;
         end
      end else if (load_valid) begin
         if (last_beat) begin
            beat_cnt <= '0;
            asm_reg  <= '0;
            if (ptr < DEPTH_C) begin
               ptr <= ptr + 1'b1;
            end else begin
               load_ovf <= 1'b1;
            end
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
            asm_reg  <= shifted;
         end
      end
   end

   // Memory write port; reset deliberately leaves contents alone.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr[IDX_W-1:0]] <= shifted;
      end
   end

   // Registered fetch; out-of-range addresses return HALT_WORD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst       <= '0;
         inst_valid <= 1'b0;
      end else begin
         inst_valid <= 1'b0;
         if (fetch_ok) begin
            inst_valid <= 1'b1;
            inst       <= in_range ? mem[fetch_addr[IDX_W-1:0]] : HALT_WORD;
         end
      end
   end

endmodule
